// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and common word types.
//   DATA_W     - width of a datapath word / register
//   REG_ADDR_W - width of a register index (rs/rt/rd fields)
//   NUM_REGS   - number of architectural registers, including hardwired r0
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    // r0 always reads as zero and ignores writes
    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : mips_pkg

// File: rtl/regfile_read_port.sv
// Combinational read port of the register file.
// Ports:
//   rdReg  - register index to read
//   regs   - full register array from the owning register file
//   rdData - contents of regs[rdReg], forced to zero for r0
module regfile_read_port
    import mips_pkg::*;
(
    input  reg_addr_t rdReg,
    input  word_t     regs [NUM_REGS],
    output word_t     rdData
);

    // r0 is forced to zero here so its storage contents never matter
    assign rdData = (rdReg == ZERO_REG) ? '0 : regs[rdReg];

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two zero-latency combinational read ports, one synchronous write port, r0 reads as zero.
// Ports:
//   clk     - system clock, state updates on rising edge
//   rst     - synchronous active-high reset, clears every register (wins over a write)
//   WrEn    - write enable
//   WrReg   - write register index (writes to r0 are dropped)
//   WrData  - write data
//   RdReg1  - read port 1 index
//   RdReg2  - read port 2 index
//   RdData1 - contents of RdReg1 (combinational, no write bypass)
//   RdData2 - contents of RdReg2 (combinational, no write bypass)
module register_file
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WrEn,
    input  logic [REG_ADDR_W-1:0] RdReg1,
    input  logic [REG_ADDR_W-1:0] RdReg2,
    input  logic [REG_ADDR_W-1:0] WrReg,
    input  logic [DATA_W-1:0]     WrData,
    output logic [DATA_W-1:0]     RdData1,
    output logic [DATA_W-1:0]     RdData2
);

    word_t regs [NUM_REGS];

    // Reset clears the whole array; otherwise commit one write, skipping r0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (WrEn && (WrReg != ZERO_REG)) begin
            regs[WrReg] <= WrData;
        end
    end

    regfile_read_port readPort1 (
        .rdReg  (RdReg1),
        .regs   (regs),
        .rdData (RdData1)
    );

    regfile_read_port readPort2 (
        .rdReg  (RdReg2),
        .regs   (regs),
        .rdData (RdData2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed literal checks followed by
// randomized traffic compared against an array model of the register file.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WrEn = 1'b0;
    logic [4:0]  RdReg1 = 5'd0;
    logic [4:0]  RdReg2 = 5'd0;
    logic [4:0]  WrReg = 5'd0;
    logic [31:0] WrData = 32'd0;
    logic [31:0] RdData1;
    logic [31:0] RdData2;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    register_file dut (
        .clk     (clk),
        .rst     (rst),
        .WrEn    (WrEn),
        .RdReg1  (RdReg1),
        .RdReg2  (RdReg2),
        .WrReg   (WrReg),
        .WrData  (WrData),
        .RdData1 (RdData1),
        .RdData2 (RdData2)
    );

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Both read ports against the model
    task automatic chkModel(input string name);
        chk({name, "_rd1"}, RdData1, expRead(RdReg1));
        chk({name, "_rd2"}, RdData2, expRead(RdReg2));
    endtask

    // Wait for the rising edge, apply the architectural update rule to the model, settle 1 ns
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (WrEn && WrReg != 5'd0) begin
            model[WrReg] = WrData;
        end
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1; WrEn = 1'b1; WrReg = 5'd3; WrData = 32'h1111_1111;
        tick();
        rst = 1'b0; WrEn = 1'b0;
        RdReg1 = 5'd31; RdReg2 = 5'd16; #1;
        chk("reset_r31", RdData1, 32'h0000_0000);
        chk("reset_r16", RdData2, 32'h0000_0000);
        RdReg1 = 5'd3; #1;
        chk("reset_r3", RdData1, 32'h0000_0000);

        // Write disable
        WrEn = 1'b0; WrReg = 5'd15; WrData = 32'hAAAA_AAAA;
        tick();
        RdReg1 = 5'd15; #1;
        chk("wren0_r15", RdData1, 32'h0000_0000);

        // Distinct registers on consecutive edges
        WrEn = 1'b1; WrReg = 5'd5; WrData = 32'hA5A5_A5A5;
        tick();
        WrReg = 5'd10; WrData = 32'h5A5A_5A5A;
        tick();
        WrEn = 1'b0; RdReg1 = 5'd5; RdReg2 = 5'd10; #1;
        chk("rd_r5", RdData1, 32'hA5A5_A5A5);
        chk("rd_r10", RdData2, 32'h5A5A_5A5A);

        // r0 protection
        WrEn = 1'b1; WrReg = 5'd0; WrData = 32'hFFFF_FFFF;
        tick();
        WrEn = 1'b0; RdReg1 = 5'd0; RdReg2 = 5'd0; #1;
        chk("r0_rd1", RdData1, 32'h0000_0000);
        chk("r0_rd2", RdData2, 32'h0000_0000);

        // Same-cycle read/write: no bypass before the edge, new value after
        WrEn = 1'b1; WrReg = 5'd20; WrData = 32'h1234_5678;
        RdReg1 = 5'd20; RdReg2 = 5'd20; #1;
        chk("nobypass_rd1", RdData1, 32'h0000_0000);
        chk("nobypass_rd2", RdData2, 32'h0000_0000);
        tick();
        chk("postedge_rd1", RdData1, 32'h1234_5678);
        chk("postedge_rd2", RdData2, 32'h1234_5678);

        // Reset priority over a same-cycle write, then a normal write succeeds
        rst = 1'b1; WrEn = 1'b1; WrReg = 5'd7; WrData = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; WrEn = 1'b0; RdReg1 = 5'd7; RdReg2 = 5'd5; #1;
        chk("rstprio_r7", RdData1, 32'h0000_0000);
        chk("rstprio_r5", RdData2, 32'h0000_0000);
        WrEn = 1'b1; WrReg = 5'd7; WrData = 32'hCAFE_F00D;
        tick();
        WrEn = 1'b0; #1;
        chk("afterrst_r7", RdData1, 32'hCAFE_F00D);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst    = ($urandom_range(0, 31) == 0);
            WrEn   = ($urandom_range(0, 3) != 0);
            WrReg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            WrData = 32'($urandom);
            RdReg1 = ($urandom_range(0, 1) == 0) ? WrReg : 5'($urandom_range(0, 31));
            RdReg2 = ($urandom_range(0, 7) == 0) ? RdReg1 : 5'($urandom_range(0, 31));
            #1;
            chkModel("rand_pre");
            tick();
            chkModel("rand_post");
            RdReg1 = 5'($urandom_range(0, 31));
            RdReg2 = 5'($urandom_range(0, 31));
            #1;
            chkModel("rand_idx");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS single-cycle datapath.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between the instruction decode fields (rs/rt/rd) and the ALU/writeback path.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of the register index ports.
- NUM_REGS, 32 (2**ADDR_W), number of registers, including hardwired register 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset; clears all registers.
- WrEn  input  1  write enable; a write occurs at the rising edge when high.
- RdReg1  input  ADDR_W  read port 1 register index.
- RdReg2  input  ADDR_W  read port 2 register index.
- WrReg  input  ADDR_W  write register index.
- WrData  input  DATA_W  write data.
- RdData1  output  DATA_W  contents of register RdReg1.
- RdData2  output  DATA_W  contents of register RdReg2.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Storage: NUM_REGS x DATA_W array. Entry 0 always reads 0.
- Reset:
  - On a rising edge with rst=1, all entries become 0.
  - rst has priority over any write in the same cycle.
  - Reset asserted mid-operation discards any pending write.
- Write:
  - On a rising edge with rst=0, WrEn=1 and WrReg!=0, the entry at WrReg takes WrData.
  - WrEn=0: no entry changes.
  - WrReg=0: the write is silently dropped.
- Read:
  - Purely combinational, zero latency.
  - RdDataN = 0 when RdRegN == 0; otherwise RdDataN = current contents of entry RdRegN.
  - Outputs follow index changes within the same cycle, with no clock involvement.
- Read/write to the same index in the same cycle:
  - No bypass. RdData shows the old value until the rising edge commits the write, then the new value immediately after the edge.
  - Both read ports may address the same register and return identical data.
- Outputs after reset: RdData1 = RdData2 = 0 for every index.
- Before the first reset, contents are unspecified (X in simulation), except that entry 0 reads 0.
- No X-propagation handling is required beyond normal RTL semantics.

Decomposition:
- Shared package (mips_pkg): DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0, and the typedefs reg_addr_t (logic [4:0]) and word_t (logic [31:0]).
- One sub-module is natural: regfile_read_port. It takes an index and the array, and returns the data with the register-0 zero-forcing. It is instantiated twice, once per read port.
- Write/reset logic stays in the top module.

Test Plan:
- Reset: hold rst=1 for one rising edge, then read RdReg1=31 and RdReg2=16 -> both RdData = 0x00000000.
- Write/read distinct registers:
  - Write 0xA5A5A5A5 to r5, then 0x5A5A5A5A to r10 on consecutive edges with WrEn=1.
  - Then, with WrEn=0, read RdReg1=5 and RdReg2=10 -> 0xA5A5A5A5 and 0x5A5A5A5A.
- Register 0 protection: WrEn=1, WrReg=0, WrData=0xFFFFFFFF, one edge; then RdReg1=0 -> 0x00000000.
- Write disable: WrEn=0, WrReg=15, WrData=0xAAAAAAAA, one edge after reset; then RdReg1=15 -> 0x00000000.
- Same-cycle read/write:
  - Set WrEn=1, WrReg=20, WrData=0x12345678 and RdReg1=RdReg2=20.
  - Before the edge -> 0 (old value, no bypass).
  - 1 ns after the edge -> both 0x12345678.
- Reset priority: rst=1 and WrEn=1 writing 0xDEADBEEF to r7 in the same cycle -> r7 reads 0 after the edge. A subsequent write with rst=0 then succeeds.
